systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_if.sv | 28 ++
 rtl/systolic_feeder.sv | 157 +++++++++++++++
 tb/tb_systolic_feeder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if
// Byte-stream load channel into the systolic feeder.
//   in_data  : operand byte (A row-major, then B row-major)
//   in_valid : in_data holds a byte this cycle
//   in_ready : feeder accepts a byte this cycle
//   flush    : abort a partially loaded operand set
// master : the producer of operand bytes
// slave  : the feeder
interface systolic_feeder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;

  modport master (
    output in_data,
    output in_valid,
    output flush,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  flush,
    output in_ready
  );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder
// Buffers two 3x3 byte matrices A and B, then drives them diagonally skewed
// into a 3x3 systolic array: row_i carries A row i delayed by i steps,
// col_j carries B column j delayed by j steps.
// Sequence per operation: LOAD (18 bytes) -> CLEAR (1 cycle) ->
// FEED (5 steps) -> DRAIN (DRAIN_CYCLES) -> DONE (1 cycle) -> LOAD.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_bus              : load channel (slave side)
//   row0..row2          : skewed A operands
//   col0..col2          : skewed B operands
//   clear_acc           : pulse asking the array to zero its accumulators
//   feed_valid          : row*/col* carry a skew step
//   busy                : high whenever not loading
//   done                : pulse when the operation completes
module systolic_feeder #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  systolic_feeder_if.slave    in_bus,
  output logic [7:0]          row0,
  output logic [7:0]          row1,
  output logic [7:0]          row2,
  output logic [7:0]          col0,
  output logic [7:0]          col1,
  output logic [7:0]          col2,
  output logic                clear_acc,
  output logic                feed_valid,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_SLOT  = 5'd17;
  localparam logic [2:0] LAST_STEP  = 3'd4;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_next;
  logic [4:0] load_cnt, load_cnt_next;
  logic [2:0] step, step_next;
  logic [3:0] drain_cnt, drain_cnt_next;
  logic       buf_we;

  // Slots 0..8 hold a[i][j] at i*3+j, slots 9..17 hold b[i][j] at 9+i*3+j.
  logic [7:0] buffer [0:17];

  logic [7:0] row_lane [3];
  logic [7:0] col_lane [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      load_cnt  <= '0;
      step      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      load_cnt  <= load_cnt_next;
      step      <= step_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // Flush has priority over a simultaneous byte: the byte is dropped and
  // the load restarts at slot 0. Input activity outside LOAD is ignored.
  always_comb begin
    state_next     = state;
    load_cnt_next  = load_cnt;
    step_next      = step;
    drain_cnt_next = drain_cnt;
    buf_we         = 1'b0;
    unique case (state)
      S_LOAD: begin
        if (in_bus.flush) begin
          load_cnt_next = '0;
        end else if (in_bus.in_valid) begin
          buf_we = 1'b1;
          if (load_cnt == LAST_SLOT) begin
            load_cnt_next = '0;
            state_next    = S_CLEAR;
          end else begin
            load_cnt_next = load_cnt + 5'd1;
          end
        end
      end
      S_CLEAR: begin
        step_next  = '0;
        state_next = S_FEED;
      end
      S_FEED: begin
        if (step == LAST_STEP) begin
          step_next      = '0;
          drain_cnt_next = '0;
          state_next     = S_DRAIN;
        end else begin
          step_next = step + 3'd1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          drain_cnt_next = '0;
          state_next     = S_DONE;
        end else begin
          drain_cnt_next = drain_cnt + 4'd1;
        end
      end
      S_DONE: begin
        state_next = S_LOAD;
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase
  end

  // Operand storage carries no reset; every load rewrites all 18 slots.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buffer[load_cnt] <= in_bus.in_data;
    end
  end

  // Lane k at step t shows element (t-k) of its row/column when that index
  // falls in 0..2; otherwise the lane idles at zero.
  always_comb begin
    for (int lane = 0; lane < 3; lane++) begin
      row_lane[lane] = '0;
      col_lane[lane] = '0;
      if (state == S_FEED && int'(step) >= lane && int'(step) - lane <= 2) begin
        row_lane[lane] = buffer[5'(lane * 3 + int'(step) - lane)];
        col_lane[lane] = buffer[5'(9 + (int'(step) - lane) * 3 + lane)];
      end
    end
  end

  assign row0 = row_lane[0];
  assign row1 = row_lane[1];
  assign row2 = row_lane[2];
  assign col0 = col_lane[0];
  assign col1 = col_lane[1];
  assign col2 = col_lane[2];

  assign in_bus.in_ready = (state == S_LOAD);
  assign clear_acc       = (state == S_CLEAR);
  assign feed_valid      = (state == S_FEED);
  assign busy            = (state != S_LOAD);
  assign done            = (state == S_DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
// Runs two feeders in lockstep from the same byte stream: dut_a with
// DRAIN_CYCLES=2 and dut_b with DRAIN_CYCLES=1. Expected skew vectors are
// queued when the 18th byte is loaded and popped during the feed steps.
module tb_systolic_feeder;

  typedef logic [47:0] feed_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] drv_data;
  logic       drv_valid;
  logic       drv_flush;

  systolic_feeder_if bus_a ();
  systolic_feeder_if bus_b ();

  assign bus_a.in_data  = drv_data;
  assign bus_a.in_valid = drv_valid;
  assign bus_a.flush    = drv_flush;
  assign bus_b.in_data  = drv_data;
  assign bus_b.in_valid = drv_valid;
  assign bus_b.flush    = drv_flush;

  logic [7:0] row0_a, row1_a, row2_a, col0_a, col1_a, col2_a;
  logic [7:0] row0_b, row1_b, row2_b, col0_b, col1_b, col2_b;
  logic       clr_a, fv_a, busy_a, done_a;
  logic       clr_b, fv_b, busy_b, done_b;
  feed_t      feed_a, feed_b;

  assign feed_a = {row0_a, row1_a, row2_a, col0_a, col1_a, col2_a};
  assign feed_b = {row0_b, row1_b, row2_b, col0_b, col1_b, col2_b};

  systolic_feeder #(.DRAIN_CYCLES(2)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_bus     (bus_a),
    .row0       (row0_a),
    .row1       (row1_a),
    .row2       (row2_a),
    .col0       (col0_a),
    .col1       (col1_a),
    .col2       (col2_a),
    .clear_acc  (clr_a),
    .feed_valid (fv_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  systolic_feeder #(.DRAIN_CYCLES(1)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_bus     (bus_b),
    .row0       (row0_b),
    .row1       (row1_b),
    .row2       (row2_b),
    .col0       (col0_b),
    .col1       (col1_b),
    .col2       (col2_b),
    .clear_acc  (clr_b),
    .feed_valid (fv_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  always #5 clk = ~clk;

  feed_t      exp_q [$];
  logic [7:0] model_buf [18];
  int         model_cnt;
  int         tests;
  int         fails;

  task automatic check_output(input string tag, input feed_t obs, input feed_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check_output(tag, {47'b0, obs}, {47'b0, exp});
  endtask

  // Skew schedule written out step by step; a[i][j]=buf[i*3+j], b[i][j]=buf[9+i*3+j].
  function automatic feed_t expected_step(input int t);
    feed_t v;
    v = '0;
    case (t)
      0: v = {model_buf[0], 8'h00,        8'h00,
              model_buf[9], 8'h00,        8'h00};
      1: v = {model_buf[1], model_buf[3], 8'h00,
              model_buf[12], model_buf[10], 8'h00};
      2: v = {model_buf[2], model_buf[4], model_buf[6],
              model_buf[15], model_buf[13], model_buf[11]};
      3: v = {8'h00,        model_buf[5], model_buf[7],
              8'h00,        model_buf[16], model_buf[14]};
      4: v = {8'h00,        8'h00,        model_buf[8],
              8'h00,        8'h00,        model_buf[17]};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_transfer(input logic [7:0] d);
    model_buf[model_cnt] = d;
    model_cnt++;
    if (model_cnt == 18) begin
      model_cnt = 0;
      for (int t = 0; t < 5; t++) exp_q.push_back(expected_step(t));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers n bytes (base+i, or random when base is 0), optionally with an
  // idle cycle between bytes; ends one cycle after the final transfer edge.
  task automatic apply_stimulus(input int n, input bit gaps, input int base);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = (base == 0) ? 8'($urandom_range(255)) : 8'(base + i);
      drv_valid = 1'b1;
      drv_data  = d;
      drv_flush = 1'b0;
      check_bit("ready_a_load", bus_a.in_ready, 1'b1);
      check_bit("ready_b_load", bus_b.in_ready, 1'b1);
      tick();
      model_transfer(d);
      if (gaps && i != n - 1) begin
        drv_valid = 1'b0;
        drv_data  = 8'($urandom_range(255));
        tick();
      end
    end
    drv_valid = 1'b0;
    drv_flush = 1'b0;
  endtask

  task automatic check_ctrl(input string who, input int d, input int c,
                            input logic clr, input logic fv, input logic bsy,
                            input logic dn, input logic rdy);
    check_bit({who, "_clear_acc"},  clr, c == 1);
    check_bit({who, "_feed_valid"}, fv,  c >= 2 && c <= 6);
    check_bit({who, "_busy"},       bsy, c <= 7 + d);
    check_bit({who, "_done"},       dn,  c == 7 + d);
    check_bit({who, "_in_ready"},   rdy, !(c <= 7 + d));
  endtask

  // Walks cycles k+1..k+9 after the last transfer edge k. With junk set,
  // 0xFF bytes and flush pulses are offered while both DUTs are busy.
  task automatic check_operation(input bit junk, input bit const_t2);
    feed_t e;
    for (int c = 1; c <= 9; c++) begin
      if (junk && c <= 7) begin
        drv_valid = 1'b1;
        drv_data  = 8'hFF;
        drv_flush = (c % 2 == 1);
      end else begin
        drv_valid = 1'b0;
        drv_flush = 1'b0;
      end
      check_ctrl("a", 2, c, clr_a, fv_a, busy_a, done_a, bus_a.in_ready);
      check_ctrl("b", 1, c, clr_b, fv_b, busy_b, done_b, bus_b.in_ready);
      if (c >= 2 && c <= 6) begin
        check_bit("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_output("feed_a", feed_a, e);
          check_output("feed_b", feed_b, e);
        end
        if (const_t2 && c == 4)
          check_output("t2_table", feed_a, 48'h03_05_07_10_0E_0C);
      end else begin
        check_output("idle_a", feed_a, '0);
        check_output("idle_b", feed_b, '0);
      end
      tick();
    end
    drv_valid = 1'b0;
    drv_flush = 1'b0;
    check_bit("sb_drained", exp_q.size() == 0, 1'b1);
  endtask

  // Asserts reset in the middle of FEED step 2 and checks the async clear.
  task automatic reset_mid_feed();
    feed_t e;
    for (int c = 1; c <= 4; c++) begin
      if (c >= 2 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("pre_rst_feed_a", feed_a, e);
      end
      if (c < 4) tick();
    end
    check_bit("pre_rst_fv_a", fv_a, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_feed_a", feed_a, '0);
    check_output("rst_feed_b", feed_b, '0);
    check_bit("rst_fv_a",   fv_a,   1'b0);
    check_bit("rst_fv_b",   fv_b,   1'b0);
    check_bit("rst_busy_a", busy_a, 1'b0);
    check_bit("rst_busy_b", busy_b, 1'b0);
    check_bit("rst_clr_a",  clr_a,  1'b0);
    exp_q.delete();
    model_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_bit("rst_done_a", done_a, 1'b0);
      check_bit("rst_done_b", done_b, 1'b0);
    end
    #2;
    rst_n = 1'b1;
    tick();
    check_bit("post_rst_ready_a", bus_a.in_ready, 1'b1);
    check_bit("post_rst_done_a",  done_a, 1'b0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    model_cnt = 0;
    drv_data  = 8'h00;
    drv_valid = 1'b0;
    drv_flush = 1'b0;
    rst_n     = 1'b0;

    #12;
    check_output("reset_feed_a", feed_a, '0);
    check_output("reset_feed_b", feed_b, '0);
    check_bit("reset_busy_a", busy_a, 1'b0);
    check_bit("reset_done_a", done_a, 1'b0);
    check_bit("reset_clr_a",  clr_a,  1'b0);
    check_bit("reset_fv_a",   fv_a,   1'b0);
    rst_n = 1'b1;
    tick();
    check_bit("reset_ready_a", bus_a.in_ready, 1'b1);
    check_bit("reset_ready_b", bus_b.in_ready, 1'b1);

    $display("[TB] continuous load a=1..9 b=10..18");
    apply_stimulus(18, 1'b0, 1);
    check_operation(1'b0, 1'b1);

    $display("[TB] load with in_valid toggling");
    apply_stimulus(18, 1'b1, 1);
    check_operation(1'b0, 1'b1);

    $display("[TB] partial load, flush, full reload, junk while busy");
    apply_stimulus(10, 1'b0, 100);
    drv_valid = 1'b1;
    drv_flush = 1'b1;
    drv_data  = 8'hEE;
    tick();
    model_cnt = 0;
    drv_valid = 1'b0;
    drv_flush = 1'b0;
    apply_stimulus(18, 1'b0, 40);
    check_operation(1'b1, 1'b0);

    $display("[TB] back-to-back operations");
    apply_stimulus(18, 1'b0, 200);
    check_operation(1'b0, 1'b0);
    apply_stimulus(18, 1'b1, 0);
    check_operation(1'b0, 1'b0);

    $display("[TB] reset during feed, then full operation");
    apply_stimulus(18, 1'b0, 0);
    reset_mid_feed();
    apply_stimulus(18, 1'b0, 60);
    check_operation(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
